// File: rtl/downstream_cancel_writer_if.sv
// Cancel-event handshake and downstream cancel RAM bus for downstream_cancel_writer.
// master: the writer block. slave: the parser/RAM side.
interface downstream_cancel_writer_if #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 5
);
  logic               cancel_valid;
  logic               cancel_ready;
  logic [A_WIDTH-1:0] cancel_client;
  logic [D_WIDTH-1:0] cancel_qty;
  logic               flush_req;
  logic [A_WIDTH-1:0] address_read;
  logic [D_WIDTH-1:0] data_read;
  logic [A_WIDTH-1:0] downstream_address_write;
  logic [D_WIDTH-1:0] data_write;
  logic               downstream_write_enable;
  logic               memwr;

  modport master (
    input  cancel_valid, cancel_client, cancel_qty, flush_req, data_read, memwr,
    output cancel_ready, address_read, downstream_address_write, data_write,
           downstream_write_enable
  );

  modport slave (
    output cancel_valid, cancel_client, cancel_qty, flush_req, data_read, memwr,
    input  cancel_ready, address_read, downstream_address_write, data_write,
           downstream_write_enable
  );
endinterface

// File: rtl/downstream_cancel_writer.sv
// Read-modify-write front end for the per-client downstream cancel RAM.
// Adds a cancel quantity to a client's total with saturation, writes it back,
// waits for the RAM write acknowledge, and can sweep all entries to zero.
module downstream_cancel_writer #(
  parameter int unsigned D_WIDTH     = 16,
  parameter int unsigned A_WIDTH     = 5,
  parameter int unsigned A_MAX       = 32,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  downstream_cancel_writer_if.master    bus,
  output logic                          done,
  output logic                          sat_pulse,
  output logic [7:0]                    sat_count,
  output logic                          ack_err
);

  localparam int unsigned T_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_ACK,
    S_FLUSH,
    S_FLUSH_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] client_q;
  logic [D_WIDTH-1:0] qty_q;
  logic [D_WIDTH-1:0] result_q;
  logic [A_WIDTH-1:0] addr_rd_q;
  logic [A_WIDTH-1:0] idx_q;
  logic [T_W-1:0]     tcnt_q;
  logic               ready_en_q;
  logic               sat_pulse_q;
  logic [7:0]         sat_count_q;
  logic               ack_err_q;

  logic               accept;
  logic               ack_fail;
  logic               timeout;
  logic               ready;
  logic               we;
  logic [A_WIDTH-1:0] addr_w;
  logic [D_WIDTH-1:0] data_w;
  logic [D_WIDTH:0]   sum;

  assign timeout = (tcnt_q == T_W'(ACK_TIMEOUT - 1));
  assign sum     = {1'b0, bus.data_read} + {1'b0, qty_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and write-port / handshake outputs
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    accept   = 1'b0;
    ack_fail = 1'b0;
    done     = 1'b0;
    we       = 1'b0;
    addr_w   = '0;
    data_w   = '0;
    case (state_q)
      S_IDLE: begin
        ready = ready_en_q & ~bus.flush_req;
        if (bus.flush_req) begin
          state_d = S_FLUSH;
        end else if (bus.cancel_valid && ready) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        we      = 1'b1;
        addr_w  = client_q;
        data_w  = result_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (bus.memwr) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          ack_fail = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_FLUSH: begin
        we      = 1'b1;
        addr_w  = idx_q;
        state_d = S_FLUSH_ACK;
      end
      S_FLUSH_ACK: begin
        if (bus.memwr) begin
          if (idx_q == A_WIDTH'(A_MAX - 1)) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
          end
        end else if (timeout) begin
          // A missing ack aborts the sweep; the error is left sticky.
          ack_fail = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Event latch, saturating sum, flush index, ack timer and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      client_q    <= '0;
      qty_q       <= '0;
      result_q    <= '0;
      addr_rd_q   <= '0;
      idx_q       <= '0;
      tcnt_q      <= '0;
      ready_en_q  <= 1'b0;
      sat_pulse_q <= 1'b0;
      sat_count_q <= '0;
      ack_err_q   <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        client_q  <= bus.cancel_client;
        qty_q     <= bus.cancel_qty;
        addr_rd_q <= bus.cancel_client;
      end
      sat_pulse_q <= 1'b0;
      if (state_q == S_READ) begin
        result_q    <= sum[D_WIDTH] ? '1 : sum[D_WIDTH-1:0];
        sat_pulse_q <= sum[D_WIDTH];
        if (sum[D_WIDTH]) sat_count_q <= sat_count_q + 8'd1;
      end
      if (state_q == S_IDLE && state_d == S_FLUSH)
        idx_q <= '0;
      else if (state_q == S_FLUSH_ACK && state_d == S_FLUSH)
        idx_q <= idx_q + 1'b1;
      if ((state_q == S_ACK || state_q == S_FLUSH_ACK) && state_d == state_q)
        tcnt_q <= tcnt_q + 1'b1;
      else
        tcnt_q <= '0;
      if (ack_fail) ack_err_q <= 1'b1;
    end
  end

  assign bus.cancel_ready             = ready;
  assign bus.address_read             = addr_rd_q;
  assign bus.downstream_write_enable  = we;
  assign bus.downstream_address_write = addr_w;
  assign bus.data_write               = data_w;
  assign sat_pulse                    = sat_pulse_q;
  assign sat_count                    = sat_count_q;
  assign ack_err                      = ack_err_q;

endmodule
